// File: rtl/mlp_pkg.sv
// Shared types for the MLP weight loader.
// Region codes, FSM state encoding and address field widths.
package mlp_pkg;

  localparam int REGION_W = 4;
  localparam int ROW_W    = 4;
  localparam int COL_W    = 8;
  localparam int ADDR_W   = REGION_W + ROW_W + COL_W;

  typedef enum logic [REGION_W-1:0] {
    REG_L1_W = 4'h0,
    REG_L1_B = 4'h1,
    REG_L2_W = 4'h2,
    REG_L2_B = 4'h3,
    REG_PJ_W = 4'h4,
    REG_PJ_B = 4'h5
  } region_t;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_STREAM = 2'd1;
  localparam state_t ST_DRAIN  = 2'd2;
  localparam state_t ST_FINISH = 2'd3;

endpackage

// File: rtl/mlp_addr_gen.sv
// Region/row/col walker for the weight loader.
// Bias regions keep row at 0 and index entries through col.
module mlp_addr_gen
  import mlp_pkg::*;
#(
  parameter int L1_ROWS   = 16,
  parameter int L1_COLS   = 63,
  parameter int L2_ROWS   = 16,
  parameter int L2_COLS   = 256,
  parameter int PROJ_ROWS = 4,
  parameter int PROJ_COLS = 256
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_adv,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last_region,
  output logic              o_last_all
);

  region_t          r_region;
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;

  logic [ROW_W:0]   w_rows_lim;
  logic [COL_W:0]   w_cols_lim;
  logic             w_row_end;
  logic             w_col_end;

  always_comb begin
    w_rows_lim = (ROW_W+1)'(1);
    w_cols_lim = (COL_W+1)'(1);
    unique case (r_region)
      REG_L1_W: begin
        w_rows_lim = (ROW_W+1)'(L1_ROWS);
        w_cols_lim = (COL_W+1)'(L1_COLS);
      end
      REG_L1_B: w_cols_lim = (COL_W+1)'(L1_ROWS);
      REG_L2_W: begin
        w_rows_lim = (ROW_W+1)'(L2_ROWS);
        w_cols_lim = (COL_W+1)'(L2_COLS);
      end
      REG_L2_B: w_cols_lim = (COL_W+1)'(L2_ROWS);
      REG_PJ_W: begin
        w_rows_lim = (ROW_W+1)'(PROJ_ROWS);
        w_cols_lim = (COL_W+1)'(PROJ_COLS);
      end
      REG_PJ_B: w_cols_lim = (COL_W+1)'(PROJ_ROWS);
      default: ;
    endcase
  end

  assign w_col_end =
    ({1'b0, r_col} == w_cols_lim - (COL_W+1)'(1));
  assign w_row_end =
    ({1'b0, r_row} == w_rows_lim - (ROW_W+1)'(1));

  assign o_last_region = w_col_end && w_row_end;
  assign o_last_all    = o_last_region &&
                         (r_region == REG_PJ_B);
  assign o_addr        = {r_region, r_row, r_col};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_region <= REG_L1_W;
      r_row    <= '0;
      r_col    <= '0;
    end else if (i_clear) begin
      r_region <= REG_L1_W;
      r_row    <= '0;
      r_col    <= '0;
    end else if (i_adv) begin
      if (!w_col_end) begin
        r_col <= r_col + COL_W'(1);
      end else begin
        r_col <= '0;
        if (!w_row_end) begin
          r_row <= r_row + ROW_W'(1);
        end else begin
          r_row <= '0;
          if (r_region == REG_PJ_B)
            r_region <= REG_L1_W;
          else
            r_region <= region_t'(r_region + 4'd1);
        end
      end
    end
  end

endmodule

// File: rtl/mlp_weight_loader.sv
// Streams upstream weight words into the accelerator
// weight memories, region by region.
module mlp_weight_loader
  import mlp_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int L1_ROWS   = 16,
  parameter int L1_COLS   = 63,
  parameter int L2_ROWS   = 16,
  parameter int L2_COLS   = 256,
  parameter int PROJ_ROWS = 4,
  parameter int PROJ_COLS = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                acc_idle,
  output logic                busy,
  output logic                done,
  output logic                err,
  input  logic [IN_WIDTH-1:0] s_data,
  input  logic                s_valid,
  input  logic                s_last,
  output logic                s_ready,
  output logic                load_mode,
  output logic [15:0]         load_addr,
  output logic [IN_WIDTH-1:0] load_data,
  output logic                load_valid
);

  generate
    if (L1_ROWS < 1 || L1_ROWS > 16 ||
        L2_ROWS < 1 || L2_ROWS > 16 ||
        PROJ_ROWS < 1 || PROJ_ROWS > 16 ||
        L1_COLS < 1 || L1_COLS > 256 ||
        L2_COLS < 1 || L2_COLS > 256 ||
        PROJ_COLS < 1 || PROJ_COLS > 256)
    begin : g_bad_dims
      $error("mlp_weight_loader: dims out of range");
    end
  endgenerate

  state_t              r_state;
  logic                r_err;
  logic                r_abort;
  logic                r_load_valid;
  logic [15:0]         r_load_addr;
  logic [IN_WIDTH-1:0] r_load_data;

  logic [ADDR_W-1:0]   w_addr;
  logic                w_last_region;
  logic                w_last_gen;
  logic                w_last_all;
  logic                w_accept;
  logic                w_xfer;

  assign w_accept = (r_state == ST_IDLE) && start && acc_idle;
  assign w_xfer   = (r_state == ST_STREAM) && s_valid;
  // last-overall always coincides with last-of-region
  assign w_last_all = w_last_gen && w_last_region;

  mlp_addr_gen #(
    .L1_ROWS  (L1_ROWS),
    .L1_COLS  (L1_COLS),
    .L2_ROWS  (L2_ROWS),
    .L2_COLS  (L2_COLS),
    .PROJ_ROWS(PROJ_ROWS),
    .PROJ_COLS(PROJ_COLS)
  ) u_addr_gen (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_clear      (w_accept),
    .i_adv        (w_xfer),
    .o_addr       (w_addr),
    .o_last_region(w_last_region),
    .o_last_all   (w_last_gen)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_err        <= 1'b0;
      r_abort      <= 1'b0;
      r_load_valid <= 1'b0;
      r_load_addr  <= '0;
      r_load_data  <= '0;
    end else begin
      r_load_valid <= w_xfer;
      if (w_xfer) begin
        r_load_addr <= w_addr;
        r_load_data <= s_data;
      end
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_STREAM;
            r_err   <= 1'b0;
            r_abort <= 1'b0;
          end
        end
        ST_STREAM: begin
          if (w_xfer) begin
            if (w_last_all) begin
              r_state <= ST_DRAIN;
              if (!s_last) r_err <= 1'b1;
            end else if (s_last) begin
              r_state <= ST_DRAIN;
              r_err   <= 1'b1;
              r_abort <= 1'b1;
            end
          end
        end
        ST_DRAIN:
          r_state <= r_abort ? ST_IDLE : ST_FINISH;
        ST_FINISH:
          r_state <= ST_IDLE;
        default:
          r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_FINISH);
  assign err        = r_err;
  assign s_ready    = (r_state == ST_STREAM);
  assign load_mode  = (r_state == ST_STREAM) ||
                      (r_state == ST_DRAIN);
  assign load_addr  = r_load_addr;
  assign load_data  = r_load_data;
  assign load_valid = r_load_valid;

endmodule

// File: tb/tb_mlp_weight_loader.sv
// Directed bench for mlp_weight_loader with a small
// L1 2x3 / L2 2x2 / PROJ 1x2 configuration (17 words).
module tb_mlp_weight_loader;

  localparam int W = 32;
  localparam int N = 17;

  logic          clk;
  logic          rst;
  logic          start;
  logic          acc_idle;
  logic          busy;
  logic          done;
  logic          err;
  logic [W-1:0]  s_data;
  logic          s_valid;
  logic          s_last;
  logic          s_ready;
  logic          load_mode;
  logic [15:0]   load_addr;
  logic [W-1:0]  load_data;
  logic          load_valid;

  mlp_weight_loader #(
    .IN_WIDTH (W),
    .L1_ROWS  (2),
    .L1_COLS  (3),
    .L2_ROWS  (2),
    .L2_COLS  (2),
    .PROJ_ROWS(1),
    .PROJ_COLS(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .acc_idle  (acc_idle),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .load_mode (load_mode),
    .load_addr (load_addr),
    .load_data (load_data),
    .load_valid(load_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] exp_addr [N] = '{
    16'h0000, 16'h0001, 16'h0002,
    16'h0100, 16'h0101, 16'h0102,
    16'h1000, 16'h1001,
    16'h2000, 16'h2001, 16'h2100, 16'h2101,
    16'h3000, 16'h3001,
    16'h4000, 16'h4001,
    16'h5000
  };

  logic [15:0] log_addr [$];
  logic [W-1:0] log_data [$];
  int done_cnt;
  int n_assert;
  int n_fail;

  always @(negedge clk) begin
    if (load_valid) begin
      log_addr.push_back(load_addr);
      log_data.push_back(load_data);
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    done_cnt = 0;
  endtask

  task automatic do_start(input string tag);
    @(negedge clk);
    start    = 1'b1;
    acc_idle = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_ready"}, s_ready, 1);
    chk({tag, "_err_clr"}, err, 0);
  endtask

  task automatic send(input string tag, input int n,
                      input int last_at, input bit gaps);
    int i;
    int guard;
    i = 0;
    guard = 0;
    while (i < n && guard < 200) begin
      @(negedge clk);
      if (gaps && (guard % 2 == 1)) begin
        s_valid = 1'b0;
        start   = 1'b1;
      end else begin
        s_valid = 1'b1;
        start   = 1'b0;
        s_data  = 32'h100 + i;
        s_last  = (i + 1 == last_at);
      end
      guard++;
      if (s_valid && s_ready) i++;
    end
    chk({tag, "_timeout"}, (guard < 200), 1);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    start   = 1'b0;
  endtask

  task automatic check_log(input string tag, input int n);
    chk({tag, "_count"}, log_addr.size(), n);
    for (int j = 0; j < n && j < log_addr.size(); j++) begin
      chk({tag, "_addr"}, log_addr[j], exp_addr[j]);
      chk({tag, "_data"}, log_data[j], 32'h100 + j);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    acc_idle = 1'b0;
    s_data   = '0;
    s_valid  = 1'b0;
    s_last   = 1'b0;
    clear_log();

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ready", s_ready, 0);
    chk("rst_lv", load_valid, 0);
    chk("rst_lm", load_mode, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_addr", load_addr, 0);
    chk("rst_data", load_data, 0);
    rst = 1'b0;

    @(negedge clk);
    start    = 1'b1;
    acc_idle = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("gate_busy", busy, 0);
    chk("gate_ready", s_ready, 0);

    clear_log();
    do_start("nom");
    send("nom", N, N, 1'b0);
    chk("nom_drain_lv", load_valid, 1);
    chk("nom_drain_lm", load_mode, 1);
    chk("nom_drain_addr", load_addr, 16'h5000);
    chk("nom_drain_done", done, 0);
    @(negedge clk);
    chk("nom_fin_done", done, 1);
    chk("nom_fin_lv", load_valid, 0);
    chk("nom_fin_lm", load_mode, 0);
    chk("nom_fin_busy", busy, 1);
    @(negedge clk);
    chk("nom_idle_busy", busy, 0);
    chk("nom_idle_done", done, 0);
    repeat (2) @(negedge clk);
    check_log("nom", N);
    chk("nom_done_cnt", done_cnt, 1);
    chk("nom_err", err, 0);

    clear_log();
    do_start("bp");
    send("bp", N, N, 1'b1);
    repeat (4) @(negedge clk);
    check_log("bp", N);
    chk("bp_done_cnt", done_cnt, 1);
    chk("bp_err", err, 0);
    chk("bp_busy", busy, 0);

    clear_log();
    do_start("short");
    send("short", 5, 5, 1'b0);
    repeat (4) @(negedge clk);
    check_log("short", 5);
    if (log_addr.size() > 0)
      chk("short_last_addr",
          log_addr[log_addr.size()-1], 16'h0101);
    chk("short_err", err, 1);
    chk("short_done_cnt", done_cnt, 0);
    chk("short_busy", busy, 0);

    clear_log();
    do_start("long");
    send("long", N, 0, 1'b0);
    repeat (4) @(negedge clk);
    check_log("long", N);
    chk("long_err", err, 1);
    chk("long_done_cnt", done_cnt, 1);
    chk("long_ready", s_ready, 0);

    clear_log();
    do_start("rmid");
    send("rmid", 8, 0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("rmid_lv", load_valid, 0);
    chk("rmid_lm", load_mode, 0);
    chk("rmid_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rmid_count", log_addr.size(), 8);
    chk("rmid_done_cnt", done_cnt, 0);

    clear_log();
    do_start("reload");
    send("reload", N, N, 1'b0);
    repeat (4) @(negedge clk);
    check_log("reload", N);
    chk("reload_done_cnt", done_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
